// File: rtl/lfsr_pkg.sv
// Shared constants, FSM encoding and LFSR step function for the offset finder.
// Contents: LFSR_W width, default tap masks POLY0_DEFAULT/POLY1_DEFAULT,
//           state_t encoding and lfsr_next().
package lfsr_pkg;

  localparam int LFSR_W = 17;

  localparam logic [LFSR_W-1:0] POLY0_DEFAULT = 17'h1D258;
  localparam logic [LFSR_W-1:0] POLY1_DEFAULT = 17'h17E04;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Fibonacci step: shift left, new LSB is the parity of the tapped bits.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s,
                                                  input logic [LFSR_W-1:0] poly);
    return {s[LFSR_W-2:0], ^(s & poly)};
  endfunction

endpackage

// File: rtl/lfsr17_stepper.sv
// 17-bit Fibonacci LFSR register that can be loaded or advanced one step.
// Ports: clk; load/load_value (load wins over step); step advances by one;
//        state is the current register value.
module lfsr17_stepper
  import lfsr_pkg::*;
#(
  parameter logic [LFSR_W-1:0] POLY = POLY0_DEFAULT
) (
  input  logic              clk,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_value,
  input  logic              step,
  output logic [LFSR_W-1:0] state
);

  always_ff @(posedge clk) begin
    if (load) begin
      state <= load_value;
    end else if (step) begin
      state <= lfsr_next(state, POLY);
    end
  end

endmodule

// File: rtl/lfsr_offset_finder.sv
// Finds the offset of a decoded 17-bit sample within two LFSR sequences.
// Ports: clk_96MHz, reset (sync, active high); data_availible strobe with
//        decoded_data/ts_last_data in; busy, result_valid/result_fail pulses,
//        held poly_id/offset/ts_out, saturating drop_count out.
module lfsr_offset_finder
  import lfsr_pkg::*;
#(
  parameter logic [LFSR_W-1:0] POLY0    = POLY0_DEFAULT,
  parameter logic [LFSR_W-1:0] POLY1    = POLY1_DEFAULT,
  parameter logic [LFSR_W-1:0] SEED     = 17'h00001,
  parameter logic [LFSR_W-1:0] MAX_ITER = 17'd131071
) (
  input  logic              clk_96MHz,
  input  logic              reset,
  input  logic              data_availible,
  input  logic [LFSR_W-1:0] decoded_data,
  input  logic [23:0]       ts_last_data,
  output logic              busy,
  output logic              result_valid,
  output logic              result_fail,
  output logic              poly_id,
  output logic [LFSR_W-1:0] offset,
  output logic [23:0]       ts_out,
  output logic [7:0]        drop_count
);

  localparam logic [LFSR_W-1:0] LAST_K = MAX_ITER - 17'd1;

  state_t            state;
  state_t            state_nxt;
  logic [LFSR_W-1:0] cap_data;
  logic [23:0]       cap_ts;
  logic [LFSR_W-1:0] k;
  logic [LFSR_W-1:0] s0;
  logic [LFSR_W-1:0] s1;
  logic              hit;
  logic              capture;
  logic              match0;
  logic              match1;
  logic              finish;

  assign capture = (state == ST_IDLE) && data_availible;
  assign match0  = (s0 == cap_data);
  assign match1  = (s1 == cap_data);
  // The last compare happens at k == MAX_ITER-1, so the counter never wraps.
  assign finish  = (state == ST_SEARCH) && (match0 || match1 || (k == LAST_K));

  // Reset reloads the seed so the LFSRs hold SEED while idle after reset.
  lfsr17_stepper #(.POLY(POLY0)) u_lfsr0 (
    .clk        (clk_96MHz),
    .load       (reset || capture),
    .load_value (SEED),
    .step       (state == ST_SEARCH),
    .state      (s0)
  );

  lfsr17_stepper #(.POLY(POLY1)) u_lfsr1 (
    .clk        (clk_96MHz),
    .load       (reset || capture),
    .load_value (SEED),
    .step       (state == ST_SEARCH),
    .state      (s1)
  );

  always_ff @(posedge clk_96MHz) begin
    if (reset) begin
      state      <= ST_IDLE;
      cap_data   <= '0;
      cap_ts     <= '0;
      k          <= '0;
      hit        <= 1'b0;
      poly_id    <= 1'b0;
      offset     <= '0;
      ts_out     <= '0;
      drop_count <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        cap_data <= decoded_data;
        cap_ts   <= ts_last_data;
        k        <= '0;
      end else if (state == ST_SEARCH) begin
        k <= k + 17'd1;
      end
      if (finish) begin
        hit     <= match0 || match1;
        // POLY0 wins a simultaneous match; a miss reports 0 as well.
        poly_id <= !match0 && match1;
        offset  <= k;
        ts_out  <= cap_ts;
      end
      if (data_availible && (state != ST_IDLE) && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    busy         = (state != ST_IDLE);
    result_valid = 1'b0;
    result_fail  = 1'b0;
    case (state)
      ST_IDLE:   if (data_availible) state_nxt = ST_SEARCH;
      ST_SEARCH: if (finish) state_nxt = ST_DONE;
      ST_DONE: begin
        state_nxt    = ST_IDLE;
        result_valid = hit;
        result_fail  = !hit;
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lfsr_offset_finder.sv
// Bench for lfsr_offset_finder: three instances (default, MAX_ITER=16,
// POLY1 forced equal to POLY0) checked every cycle against a timing model.
module tb_lfsr_offset_finder;

  localparam logic [16:0] P0   = 17'h1D258;
  localparam logic [16:0] P1   = 17'h17E04;
  localparam logic [16:0] SEED = 17'h00001;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dav  [3];
  logic [16:0] dd   [3];
  logic [23:0] ts   [3];
  logic        busy_o [3];
  logic        rv   [3];
  logic        rf   [3];
  logic        pid  [3];
  logic [16:0] off  [3];
  logic [23:0] tso  [3];
  logic [7:0]  drop [3];

  logic [16:0] mp0 [3];
  logic [16:0] mp1 [3];
  int          mi  [3];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  lfsr_offset_finder u_dut0 (
    .clk_96MHz(clk), .reset(reset), .data_availible(dav[0]), .decoded_data(dd[0]),
    .ts_last_data(ts[0]), .busy(busy_o[0]), .result_valid(rv[0]), .result_fail(rf[0]),
    .poly_id(pid[0]), .offset(off[0]), .ts_out(tso[0]), .drop_count(drop[0]));

  lfsr_offset_finder #(.MAX_ITER(17'd16)) u_dut1 (
    .clk_96MHz(clk), .reset(reset), .data_availible(dav[1]), .decoded_data(dd[1]),
    .ts_last_data(ts[1]), .busy(busy_o[1]), .result_valid(rv[1]), .result_fail(rf[1]),
    .poly_id(pid[1]), .offset(off[1]), .ts_out(tso[1]), .drop_count(drop[1]));

  lfsr_offset_finder #(.POLY1(P0)) u_dut2 (
    .clk_96MHz(clk), .reset(reset), .data_availible(dav[2]), .decoded_data(dd[2]),
    .ts_last_data(ts[2]), .busy(busy_o[2]), .result_valid(rv[2]), .result_fail(rf[2]),
    .poly_id(pid[2]), .offset(off[2]), .ts_out(tso[2]), .drop_count(drop[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [16:0] lfsr_steps(input logic [16:0] s, input logic [16:0] p,
                                             input int n);
    logic [16:0] r = s;
    for (int j = 0; j < n; j++) r = {r[15:0], ^(r & p)};
    return r;
  endfunction

  // Walk both sequences offset by offset; first offset where either equals d.
  task automatic search(input logic [16:0] d, input logic [16:0] pa, input logic [16:0] pb,
                        input int maxi, output bit found, output bit which, output int k);
    logic [16:0] a = SEED;
    logic [16:0] b = SEED;
    found = 0; which = 0; k = maxi - 1;
    for (int j = 0; j < maxi; j++) begin
      if (a == d || b == d) begin
        found = 1; which = (a != d); k = j;
        break;
      end
      a = {a[15:0], ^(a & pa)};
      b = {b[15:0], ^(b & pb)};
    end
  endtask

  // ---------------- timing model ----------------
  bit          m_act [3];
  int          m_t   [3];
  int          m_end [3];
  bit          m_fnd [3];
  bit          m_pid [3];
  logic [16:0] m_off [3];
  logic [23:0] m_ts  [3];
  bit          h_pid [3];
  logic [16:0] h_off [3];
  logic [23:0] h_ts  [3];
  int          m_drop[3];
  int          last_rv_cyc [3];
  int          last_rf_cyc [3];
  bit          b_now [3];
  bit          at_end[3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_act[i] = 0; m_t[i] = 0; m_end[i] = 0; m_fnd[i] = 0; m_pid[i] = 0;
      m_off[i] = '0; m_ts[i] = '0; h_pid[i] = 0; h_off[i] = '0; h_ts[i] = '0;
      m_drop[i] = 0; last_rv_cyc[i] = -1; last_rf_cyc[i] = -1;
      dav[i] = 1'b0; dd[i] = '0; ts[i] = '0;
    end
    mp0[0] = P0; mp1[0] = P1; mi[0] = 131071;
    mp0[1] = P0; mp1[1] = P1; mi[1] = 16;
    mp0[2] = P0; mp1[2] = P0; mi[2] = 131071;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      b_now[i]  = m_act[i] && (cyc > m_t[i]) && (cyc <= m_end[i]);
      at_end[i] = m_act[i] && (cyc == m_end[i]);
      if (at_end[i]) begin
        h_pid[i] = m_pid[i]; h_off[i] = m_off[i]; h_ts[i] = m_ts[i];
      end
      check($sformatf("busy%0d", i), 32'(busy_o[i]), 32'(b_now[i]));
      check($sformatf("result_valid%0d", i), 32'(rv[i]), 32'(at_end[i] && m_fnd[i]));
      check($sformatf("result_fail%0d", i), 32'(rf[i]), 32'(at_end[i] && !m_fnd[i]));
      check($sformatf("poly_id%0d", i), 32'(pid[i]), 32'(h_pid[i]));
      check($sformatf("offset%0d", i), 32'(off[i]), 32'(h_off[i]));
      check($sformatf("ts_out%0d", i), 32'(tso[i]), 32'(h_ts[i]));
      check($sformatf("drop_count%0d", i), 32'(drop[i]), 32'(m_drop[i]));
      if (rv[i] === 1'b1) last_rv_cyc[i] = cyc;
      if (rf[i] === 1'b1) last_rf_cyc[i] = cyc;
      if (at_end[i]) m_act[i] = 0;
      if (reset) begin
        m_act[i] = 0; h_pid[i] = 0; h_off[i] = '0; h_ts[i] = '0; m_drop[i] = 0;
      end else if (dav[i]) begin
        if (b_now[i]) begin
          if (m_drop[i] < 255) m_drop[i]++;
        end else begin
          bit f; bit w; int k;
          search(dd[i], mp0[i], mp1[i], mi[i], f, w, k);
          m_act[i] = 1; m_t[i] = cyc; m_fnd[i] = f;
          m_end[i] = f ? cyc + 2 + k : cyc + 1 + mi[i];
          m_pid[i] = f ? w : 1'b0;
          m_off[i] = 17'(k);
          m_ts[i]  = ts[i];
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int i, input logic [16:0] d, input logic [23:0] t_in,
                        output int t);
    dav[i] = 1'b1; dd[i] = d; ts[i] = t_in; t = cyc;
    step(1);
    dav[i] = 1'b0;
  endtask

  initial begin
    int t, t3, kexp;
    bit f, w;
    logic [16:0] d;

    // Pin the model against hand-derived values.
    check("pin_p0_5", 32'(lfsr_steps(SEED, P0, 5)), 32'h23);
    check("pin_p1_5", 32'(lfsr_steps(SEED, P1, 5)), 32'h24);
    search(17'h24, P0, P1, 131071, f, w, kexp);
    check("pin_search_k", 32'(kexp), 32'd5);
    check("pin_search_poly", 32'(w), 32'd1);

    step(3);
    reset = 1'b0;
    step(1);
    check("reset_busy", 32'(busy_o[0]), 32'd0);
    check("reset_offset", 32'(off[0]), 32'd0);
    check("reset_drop", 32'(drop[0]), 32'd0);

    // Sample equal to SEED: match at offset 0.
    strobe(0, 17'h00001, 24'hABCDE1, t);
    step(3);
    check("seed_rv_cycle", 32'(last_rv_cyc[0]), 32'(t + 2));
    check("seed_offset", 32'(off[0]), 32'd0);
    check("seed_poly", 32'(pid[0]), 32'd0);

    // POLY1 after 5 steps.
    strobe(0, 17'h00024, 24'h123456, t);
    step(8);
    check("p1_rv_cycle", 32'(last_rv_cyc[0]), 32'(t + 7));
    check("p1_offset", 32'(off[0]), 32'd5);
    check("p1_poly", 32'(pid[0]), 32'd1);
    check("p1_ts", 32'(tso[0]), 32'h123456);

    // Three strobes dropped during one search.
    d = lfsr_steps(SEED, P0, 20);
    search(d, P0, P1, 131071, f, w, kexp);
    strobe(0, d, 24'h00BEEF, t);
    step(2); strobe(0, 17'h00001, 24'h111111, t3);
    step(2); strobe(0, 17'h00002, 24'h222222, t3);
    step(2); strobe(0, 17'h00004, 24'h333333, t3);
    step(30);
    check("drop_three", 32'(drop[0]), 32'd3);
    check("drop_rv_cycle", 32'(last_rv_cyc[0]), 32'(t + 2 + kexp));
    check("drop_offset", 32'(off[0]), 32'(kexp));
    check("drop_ts", 32'(tso[0]), 32'h00BEEF);

    // Strobe in the result cycle is dropped; the next cycle starts a search.
    strobe(0, 17'h00001, 24'h000A01, t);
    step(1);
    strobe(0, 17'h00005, 24'h000A02, t3);
    strobe(0, 17'h00002, 24'h000A03, t3);
    step(4);
    check("done_drop", 32'(drop[0]), 32'd4);
    check("b2b_rv_cycle", 32'(last_rv_cyc[0]), 32'(t3 + 3));
    check("b2b_offset", 32'(off[0]), 32'd1);
    check("b2b_ts", 32'(tso[0]), 32'h000A03);

    // Zero never matches: fail after MAX_ITER=16 offsets.
    strobe(1, 17'h00000, 24'h0F0F0F, t);
    step(20);
    check("fail_cycle", 32'(last_rf_cyc[1]), 32'(t + 17));
    check("fail_offset", 32'(off[1]), 32'd15);
    check("fail_poly", 32'(pid[1]), 32'd0);

    // Both polynomials identical: poly 0 reported.
    strobe(2, 17'h00023, 24'h00C0DE, t);
    step(8);
    check("both_rv_cycle", 32'(last_rv_cyc[2]), 32'(t + 7));
    check("both_poly", 32'(pid[2]), 32'd0);
    check("both_offset", 32'(off[2]), 32'd5);

    // Reset ten cycles into a search, with a strobe in the reset cycle.
    strobe(0, lfsr_steps(SEED, P0, 40), 24'h0DEAD0, t);
    step(9);
    reset = 1'b1; dav[0] = 1'b1; dd[0] = 17'h00001;
    step(1);
    reset = 1'b0; dav[0] = 1'b0;
    step(50);
    check("abort_no_rv", 32'(last_rv_cyc[0] < t), 32'd1);
    check("abort_busy", 32'(busy_o[0]), 32'd0);
    check("abort_offset", 32'(off[0]), 32'd0);
    check("abort_ts", 32'(tso[0]), 32'd0);
    check("abort_drop", 32'(drop[0]), 32'd0);
    strobe(0, 17'h00001, 24'h000777, t);
    step(3);
    check("after_rst_rv", 32'(last_rv_cyc[0]), 32'(t + 2));
    check("after_rst_ts", 32'(tso[0]), 32'h000777);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
